// File: rtl/weight_bram_writer_pkg.sv
// rtl/weight_bram_writer_pkg.sv - shared DRAM access state encodings and word-packing constants
package weight_bram_writer_pkg;

  // Encodings shared with the DRAM access controller.
  typedef enum logic [2:0] {
    DRAM_RESET   = 3'b000,
    DRAM_PARAMS  = 3'b001,
    DRAM_WEIGHTS = 3'b010,
    DRAM_SIGNALS = 3'b011,
    DRAM_INPUTS  = 3'b100,
    DRAM_FILLED  = 3'b101
  } dram_state_e;

  typedef enum logic [1:0] {
    WR_IDLE,
    WR_WEIGHT,
    WR_SIGNAL,
    WR_DONE
  } wr_state_e;

  localparam int DEF_DRAM_BEAT_W = 32;
  localparam int DEF_ADDR_W      = 16;
  localparam int DEF_N_ROWS      = 16;
  localparam int DEF_F_WIDTH     = 8;
  localparam int DEF_ROM_SIG_W   = 100;

  function automatic int beats_per_word(input int word_w, input int beat_w);
    return (word_w + beat_w - 1) / beat_w;
  endfunction

endpackage

// File: rtl/weight_bram_writer_dram_word_packer.sv
// rtl/weight_bram_writer_dram_word_packer.sv - packs DRAM beats into one BRAM word and issues writes
module dram_word_packer #(
  parameter int WORD_W = 128,
  parameter int BEAT_W = 32,
  parameter int BEATS  = 4,
  parameter int ADDR_W = 16
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              clr_i,
  input  logic              beat_valid_i,
  input  logic [BEAT_W-1:0] beat_data_i,
  input  logic              flush_i,
  output logic              wr_en_o,
  output logic [ADDR_W-1:0] wr_addr_o,
  output logic [WORD_W-1:0] wr_data_o,
  output logic              drop_o
);

  localparam int BUF_W = BEATS * BEAT_W;
  localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BEATS - 1);

  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [BUF_W-1:0]  buf_q, buf_d, buf_v;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              full_q, full_d;
  logic              wr_en_q, wr_en_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [WORD_W-1:0] wr_data_q, wr_data_d;
  logic              complete;

  always_comb begin
    cnt_d     = cnt_q;
    buf_d     = buf_q;
    buf_v     = buf_q;
    addr_d    = addr_q;
    full_d    = full_q;
    wr_en_d   = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    drop_o    = 1'b0;
    complete  = 1'b0;

    if (beat_valid_i) begin
      for (int k = 0; k < BEATS; k++) begin
        if (cnt_q == CNT_W'(k)) buf_v[k*BEAT_W +: BEAT_W] = beat_data_i;
      end
      buf_d    = buf_v;
      cnt_d    = cnt_q + 1'b1;
      complete = (cnt_q == LAST_CNT);
    end else if (flush_i && cnt_q != '0) begin
      complete = 1'b1;
    end

    // Buffer is cleared after every word, so a flushed partial word is already zero-filled.
    if (complete) begin
      cnt_d = '0;
      buf_d = '0;
      if (full_q) begin
        drop_o = 1'b1;
      end else begin
        wr_en_d   = 1'b1;
        wr_addr_d = addr_q;
        wr_data_d = buf_v[WORD_W-1:0];
        if (addr_q == '1) full_d = 1'b1;
        else              addr_d = addr_q + 1'b1;
      end
    end

    if (clr_i) begin
      cnt_d     = '0;
      buf_d     = '0;
      addr_d    = '0;
      full_d    = 1'b0;
      wr_en_d   = 1'b0;
      wr_addr_d = '0;
      wr_data_d = '0;
      drop_o    = 1'b0;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q     <= '0;
      buf_q     <= '0;
      addr_q    <= '0;
      full_q    <= 1'b0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
    end else begin
      cnt_q     <= cnt_d;
      buf_q     <= buf_d;
      addr_q    <= addr_d;
      full_q    <= full_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
    end
  end

  assign wr_en_o   = wr_en_q;
  assign wr_addr_o = wr_addr_q;
  assign wr_data_o = wr_data_q;

endmodule

// File: rtl/weight_bram_writer.sv
// rtl/weight_bram_writer.sv - routes DRAM read beats into weight/signal BRAM word packers
module weight_bram_writer
  import weight_bram_writer_pkg::*;
#(
  parameter int DATA_IN_DRAM_WIDTH = DEF_DRAM_BEAT_W,
  parameter int SIG_ADDRS_WIDTH    = DEF_ADDR_W,
  parameter int N_ROWS_ARRAY       = DEF_N_ROWS,
  parameter int F_WIDTH            = DEF_F_WIDTH,
  parameter int ROM_SIG_WIDTH      = DEF_ROM_SIG_W
) (
  input  logic                            clk_i,
  input  logic                            weight_wr_addr_rst,
  input  logic [2:0]                      dram_access_state_i,
  input  logic [DATA_IN_DRAM_WIDTH-1:0]   dram_data_i,
  input  logic                            dram_valid_i,
  output logic                            dram_ready_o,
  output logic                            weight_wr_en_o,
  output logic [SIG_ADDRS_WIDTH-1:0]      weight_wr_addr_o,
  output logic [F_WIDTH*N_ROWS_ARRAY-1:0] weight_wr_data_o,
  output logic                            signal_wr_en_o,
  output logic [SIG_ADDRS_WIDTH-1:0]      signal_wr_addr_o,
  output logic [ROM_SIG_WIDTH-1:0]        signal_wr_data_o,
  output logic                            weights_done_o,
  output logic                            signals_done_o,
  output logic                            overflow_o
);

  localparam int WEIGHT_W = F_WIDTH * N_ROWS_ARRAY;
  localparam int BEATS_W  = beats_per_word(WEIGHT_W, DATA_IN_DRAM_WIDTH);
  localparam int BEATS_S  = beats_per_word(ROM_SIG_WIDTH, DATA_IN_DRAM_WIDTH);

  wr_state_e   fsm_q, fsm_d;
  logic        weights_done_q, weights_done_d;
  logic        signals_done_q, signals_done_d;
  logic        overflow_q, overflow_d;
  dram_state_e st;
  logic        sync_clr, w_beat, s_beat, w_flush, s_flush, w_drop, s_drop;

  assign st       = dram_state_e'(dram_access_state_i);
  assign sync_clr = (st == DRAM_RESET);

  // A signal beat may arrive in the same cycle the weight region closes; it is still accepted.
  assign dram_ready_o = (fsm_q == WR_WEIGHT && (st == DRAM_WEIGHTS || st == DRAM_SIGNALS)) ||
                        (fsm_q == WR_SIGNAL && st == DRAM_SIGNALS);
  assign w_beat  = dram_valid_i && fsm_q == WR_WEIGHT && st == DRAM_WEIGHTS;
  assign s_beat  = dram_valid_i && (fsm_q == WR_WEIGHT || fsm_q == WR_SIGNAL) && st == DRAM_SIGNALS;
  assign w_flush = fsm_q == WR_WEIGHT && st != DRAM_WEIGHTS && !sync_clr;
  assign s_flush = fsm_q == WR_SIGNAL && st != DRAM_SIGNALS && !sync_clr;

  always_comb begin
    fsm_d = fsm_q;
    case (fsm_q)
      WR_IDLE: begin
        if (st == DRAM_WEIGHTS)      fsm_d = WR_WEIGHT;
        else if (st == DRAM_SIGNALS) fsm_d = WR_SIGNAL;
      end
      WR_WEIGHT: begin
        if (st != DRAM_WEIGHTS) fsm_d = (st == DRAM_SIGNALS) ? WR_SIGNAL : WR_DONE;
      end
      WR_SIGNAL: begin
        if (st != DRAM_SIGNALS) fsm_d = WR_DONE;
      end
      default: fsm_d = fsm_q;
    endcase
    if (sync_clr) fsm_d = WR_IDLE;

    weights_done_d = !sync_clr && (weights_done_q || w_flush);
    signals_done_d = !sync_clr && (signals_done_q || s_flush);
    overflow_d     = !sync_clr && (overflow_q || w_drop || s_drop);
  end

  always_ff @(posedge clk_i or posedge weight_wr_addr_rst) begin
    if (weight_wr_addr_rst) begin
      fsm_q          <= WR_IDLE;
      weights_done_q <= 1'b0;
      signals_done_q <= 1'b0;
      overflow_q     <= 1'b0;
    end else begin
      fsm_q          <= fsm_d;
      weights_done_q <= weights_done_d;
      signals_done_q <= signals_done_d;
      overflow_q     <= overflow_d;
    end
  end

  dram_word_packer #(
    .WORD_W (WEIGHT_W),
    .BEAT_W (DATA_IN_DRAM_WIDTH),
    .BEATS  (BEATS_W),
    .ADDR_W (SIG_ADDRS_WIDTH)
  ) u_weight_packer (
    .clk_i        (clk_i),
    .rst_i        (weight_wr_addr_rst),
    .clr_i        (sync_clr),
    .beat_valid_i (w_beat),
    .beat_data_i  (dram_data_i),
    .flush_i      (w_flush),
    .wr_en_o      (weight_wr_en_o),
    .wr_addr_o    (weight_wr_addr_o),
    .wr_data_o    (weight_wr_data_o),
    .drop_o       (w_drop)
  );

  dram_word_packer #(
    .WORD_W (ROM_SIG_WIDTH),
    .BEAT_W (DATA_IN_DRAM_WIDTH),
    .BEATS  (BEATS_S),
    .ADDR_W (SIG_ADDRS_WIDTH)
  ) u_signal_packer (
    .clk_i        (clk_i),
    .rst_i        (weight_wr_addr_rst),
    .clr_i        (sync_clr),
    .beat_valid_i (s_beat),
    .beat_data_i  (dram_data_i),
    .flush_i      (s_flush),
    .wr_en_o      (signal_wr_en_o),
    .wr_addr_o    (signal_wr_addr_o),
    .wr_data_o    (signal_wr_data_o),
    .drop_o       (s_drop)
  );

  assign weights_done_o = weights_done_q;
  assign signals_done_o = signals_done_q;
  assign overflow_o     = overflow_q;

endmodule
